// File: rtl/nf_ram_arb.sv
// nf_ram_arb: two-requester arbiter in front of one port of a dual-port RAM.
// Requester 0 is the load/store unit, requester 1 is the program loader.
// A grant is taken in IDLE and accesses are acknowledged combinationally
// while in GNT0/GNT1. Bursts are capped at max_burst accesses when the
// other requester is waiting.
// Optional feature: define NF_RAM_ARB_RR_EN to resolve IDLE ties
// round-robin. Without it, requester 0 always wins a tie.
module nf_ram_arb #(
    parameter int max_burst = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [31:0] addr_0,
    input  logic [31:0] addr_1,
    input  logic        we_0,
    input  logic        we_1,
    input  logic [31:0] wd_0,
    input  logic [31:0] wd_1,
    output logic        ack_0,
    output logic        ack_1,
    output logic [31:0] rd_0,
    output logic [31:0] rd_1,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    // Counter value of the last access a burst may take while the other side waits.
    localparam logic [4:0] burst_last = 5'(max_burst - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [31:0] addr_hold_r;
    logic [31:0] wd_hold_r;
    logic        tie_gnt1_s;
`ifdef NF_RAM_ARB_RR_EN
    logic        last_r;
`endif

    // Accept an access only from the granted requester while it still requests.
    always_comb begin
        ack_0 = (state_r == GNT0) && req_0;
        ack_1 = (state_r == GNT1) && req_1;
    end

    // Steer the accepted access onto the RAM port; otherwise hold the last address/data.
    always_comb begin
        ram_addr = addr_hold_r;
        ram_wd   = wd_hold_r;
        ram_we   = 1'b0;
        if (ack_0) begin
            ram_addr = addr_0;
            ram_wd   = wd_0;
            ram_we   = we_0;
        end else if (ack_1) begin
            ram_addr = addr_1;
            ram_wd   = wd_1;
            ram_we   = we_1;
        end else begin
            ram_we   = 1'b0;
        end
    end

    // Tie resolution in IDLE when both requesters ask at once.
    always_comb begin
`ifdef NF_RAM_ARB_RR_EN
        tie_gnt1_s = ~last_r;
`else
        tie_gnt1_s = 1'b0;
`endif
    end

    // Both read-data outputs simply mirror the RAM's registered read port.
    assign rd_0 = ram_rd;
    assign rd_1 = ram_rd;

    // Arbitration FSM with burst counter, read-valid pipeline and held port values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            rvalid_0    <= 1'b0;
            rvalid_1    <= 1'b0;
            addr_hold_r <= 32'd0;
            wd_hold_r   <= 32'd0;
`ifdef NF_RAM_ARB_RR_EN
            last_r      <= 1'b1;
`endif
        end else begin
            rvalid_0 <= ack_0 & ~we_0;
            rvalid_1 <= ack_1 & ~we_1;
            if (ack_0) begin
                addr_hold_r <= addr_0;
                wd_hold_r   <= wd_0;
            end else if (ack_1) begin
                addr_hold_r <= addr_1;
                wd_hold_r   <= wd_1;
            end
`ifdef NF_RAM_ARB_RR_EN
            if (ack_0) begin
                last_r <= 1'b0;
            end else if (ack_1) begin
                last_r <= 1'b1;
            end
`endif
            case (state_r)
                IDLE: begin
                    cnt_r <= 5'd0;
                    if (req_0 && req_1) begin
                        state_r <= tie_gnt1_s ? GNT1 : GNT0;
                    end else if (req_0) begin
                        state_r <= GNT0;
                    end else if (req_1) begin
                        state_r <= GNT1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT0: begin
                    if (req_0) begin
                        if (cnt_r == burst_last) begin
                            // Saturated burst: hand over only if the other side waits.
                            if (req_1) begin
                                state_r <= GNT1;
                                cnt_r   <= 5'd0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end else begin
                        state_r <= req_1 ? GNT1 : IDLE;
                        cnt_r   <= 5'd0;
                    end
                end
                GNT1: begin
                    if (req_1) begin
                        if (cnt_r == burst_last) begin
                            if (req_0) begin
                                state_r <= GNT0;
                                cnt_r   <= 5'd0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end else begin
                        state_r <= req_0 ? GNT0 : IDLE;
                        cnt_r   <= 5'd0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf_ram_arb.sv
// Self-checking bench for nf_ram_arb: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against
// an ownership/run-length model of the arbitration rules and a RAM model.
module tb_nf_ram_arb;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
    logic [31:0] addr_0 = 32'd0, addr_1 = 32'd0, wd_0 = 32'd0, wd_1 = 32'd0;
    logic        ack_0, ack_1, rvalid_0, rvalid_1, ram_we;
    logic [31:0] rd_0, rd_1, ram_addr, ram_wd;
    logic [31:0] ram_rd;

    int checks = 0;
    int failures = 0;

    nf_ram_arb #(.max_burst(MB)) dut (
        .clk(clk), .resetn(resetn),
        .req_0(req_0), .req_1(req_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .we_0(we_0), .we_1(we_1),
        .wd_0(wd_0), .wd_1(wd_1),
        .ack_0(ack_0), .ack_1(ack_1),
        .rd_0(rd_0), .rd_1(rd_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd),
        .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'hA5000000 + 32'(i) * 32'h01010101;
    endfunction

    // Bench RAM: synchronous write, registered read, one cycle latency.
    logic [31:0] ram_mem [16];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_we) ram_mem[ram_addr[3:0]] <= ram_wd;
        end
        ram_rd <= ram_mem[ram_addr[3:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic want);
        chk(nm, {31'd0, act}, {31'd0, want});
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner;   // -1: nobody owns the port, else requester index
    int          m_run;     // consecutive accesses by the owner
    int          m_last;    // requester granted most recently
    logic [31:0] m_haddr, m_hwd, m_rd_exp;
    logic        m_rv0, m_rv1;
    bit          m_ack0, m_ack1;
    logic [31:0] m_mem [16];

    function automatic void model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        m_haddr = 32'd0; m_hwd = 32'd0;
        m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_ack0 = 1'b0; m_ack1 = 1'b0;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        model_reset();
    end

    always @(negedge resetn) model_reset();

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic        e_a0, e_a1, e_we, oth;
        logic [31:0] e_addr, e_wd;
        if (!resetn) begin
            chk1("rst_ack_0", ack_0, 1'b0);
            chk1("rst_ack_1", ack_1, 1'b0);
            chk1("rst_ram_we", ram_we, 1'b0);
            chk1("rst_rvalid_0", rvalid_0, 1'b0);
            chk1("rst_rvalid_1", rvalid_1, 1'b0);
            chk("rst_ram_addr", ram_addr, 32'd0);
            chk("rst_ram_wd", ram_wd, 32'd0);
            model_reset();
        end else begin
            e_a0 = (m_owner == 0) && req_0;
            e_a1 = (m_owner == 1) && req_1;
            e_we = (e_a0 && we_0) || (e_a1 && we_1);
            e_addr = e_a0 ? addr_0 : (e_a1 ? addr_1 : m_haddr);
            e_wd   = e_a0 ? wd_0   : (e_a1 ? wd_1   : m_hwd);
            chk1("ack_0", ack_0, e_a0);
            chk1("ack_1", ack_1, e_a1);
            chk1("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wd", ram_wd, e_wd);
            chk1("rvalid_0", rvalid_0, m_rv0);
            chk1("rvalid_1", rvalid_1, m_rv1);
            if (m_rv0) chk("rd_0", rd_0, m_rd_exp);
            if (m_rv1) chk("rd_1", rd_1, m_rd_exp);
            // advance the model by one clock
            m_rv0 = e_a0 && !we_0;
            m_rv1 = e_a1 && !we_1;
            if (m_rv0 || m_rv1) m_rd_exp = m_mem[e_addr[3:0]];
            if (e_we) m_mem[e_addr[3:0]] = e_wd;
            m_haddr = e_addr;
            m_hwd   = e_wd;
            m_ack0  = e_a0;
            m_ack1  = e_a1;
            if (m_owner < 0) begin
                if (req_0 && req_1) begin
`ifdef NF_RAM_ARB_RR_EN
                    m_owner = (m_last == 1) ? 0 : 1;
`else
                    m_owner = 0;
`endif
                end else if (req_0) begin
                    m_owner = 0;
                end else if (req_1) begin
                    m_owner = 1;
                end
                m_run = 0;
            end else begin
                oth = (m_owner == 0) ? req_1 : req_0;
                if (e_a0 || e_a1) begin
                    m_last = m_owner;
                    m_run++;
                    if (m_run >= MB && oth) begin
                        m_owner = 1 - m_owner;
                        m_run = 0;
                    end
                end else begin
                    m_owner = oth ? 1 - m_owner : -1;
                    m_run = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic all_low();
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    endtask

    initial begin
        int n;
        bit e0, e1;
        // reset state
        settle();
        chk1("reset_ack_0", ack_0, 1'b0);
        chk("reset_ram_addr", ram_addr, 32'd0);
        cyc(); cyc(); resetn = 1'b1;

        // single read of address 5
        cyc(); req_0 = 1'b1; addr_0 = 32'd5; we_0 = 1'b0;
        settle(); chk1("rd_idle_noack", ack_0, 1'b0);
        cyc(); settle();
        chk1("rd_ack_cycle1", ack_0, 1'b1);
        chk("rd_ram_addr", ram_addr, 32'd5);
        cyc(); req_0 = 1'b0;
        settle();
        chk1("rd_rvalid_cycle2", rvalid_0, 1'b1);
        chk("rd_data", rd_0, 32'hDEADBEEF);
        chk1("rd_no_rvalid_1", rvalid_1, 1'b0);

        // write then read by requester 1
        n = 0;
        cyc(); req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'd8; wd_1 = 32'h12345678;
        settle(); chk1("wr_idle_noack", ack_1, 1'b0); n += int'(ram_we);
        cyc(); settle();
        chk1("wr_ack", ack_1, 1'b1);
        chk("wr_ram_wd", ram_wd, 32'h12345678);
        n += int'(ram_we);
        cyc(); we_1 = 1'b0;
        settle();
        chk1("wr_rd_ack", ack_1, 1'b1);
        chk1("wr_no_rvalid", rvalid_1, 1'b0);
        n += int'(ram_we);
        cyc(); req_1 = 1'b0;
        settle();
        n += int'(ram_we);
        chk("wr_one_we_pulse", 32'(n), 32'd1);
        chk1("wr_rvalid", rvalid_1, 1'b1);
        chk("wr_readback", rd_1, 32'h12345678);
        cyc(); all_low();

        // contention: alternating bursts of MB, no gaps, no overlap
        for (int i = 0; i < 17; i++) begin
            cyc();
            req_0 = 1'b1; req_1 = 1'b1; addr_0 = 32'd1; addr_1 = 32'd2;
            we_0 = 1'b0; we_1 = 1'b0;
            settle();
            e0 = (i > 0) && ((((i - 1) / MB) % 2) == 0);
            e1 = (i > 0) && !e0;
            chk1("cont_ack_0", ack_0, e0);
            chk1("cont_ack_1", ack_1, e1);
        end
        cyc(); all_low();
        cyc();

        // IDLE ties: two single simultaneous requests
        cyc(); req_0 = 1'b1; req_1 = 1'b1;
        settle(); chk1("tie1_idle", ack_0 | ack_1, 1'b0);
        cyc(); settle();
        chk1("tie1_ack_0", ack_0, 1'b1);
        chk1("tie1_ack_1", ack_1, 1'b0);
        cyc(); all_low();
        cyc(); req_0 = 1'b1; req_1 = 1'b1;
        cyc(); settle();
`ifdef NF_RAM_ARB_RR_EN
        chk1("tie2_ack_0", ack_0, 1'b0);
        chk1("tie2_ack_1", ack_1, 1'b1);
`else
        chk1("tie2_ack_0", ack_0, 1'b1);
        chk1("tie2_ack_1", ack_1, 1'b0);
`endif
        cyc(); all_low();
        cyc();

        // lone burst: 10 consecutive acks
        n = 0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            req_0 = 1'b1; we_0 = 1'b0;
            addr_0 = (i == 0) ? 32'd0 : 32'(i - 1);
            settle();
            if (ack_0) n++;
        end
        cyc(); all_low();
        chk("lone_burst_acks", 32'(n), 32'd10);
        cyc();

        // reset right after a read ack
        cyc(); req_0 = 1'b1; addr_0 = 32'd3; we_0 = 1'b0;
        cyc(); settle();
        chk1("rstrd_ack", ack_0, 1'b1);
        #1 resetn = 1'b0;
        cyc(); settle();
        chk1("rstrd_no_rvalid", rvalid_0, 1'b0);
        chk1("rstrd_no_ack", ack_0, 1'b0);
        chk("rstrd_ram_addr", ram_addr, 32'd0);
        cyc(); req_0 = 1'b0; resetn = 1'b1;
        settle(); chk1("rstrd_after_rel", rvalid_0, 1'b0);
        cyc(); settle(); chk1("rstrd_after_rel2", rvalid_0, 1'b0);

        // randomized traffic, requesters hold their request until accepted
        for (int k = 0; k < 3000; k++) begin
            cyc();
            resetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if (req_0 && !m_ack0) begin
                if ($urandom_range(0, 9) == 0) req_0 = 1'b0;
            end else begin
                req_0  = ($urandom_range(0, 2) != 0);
                addr_0 = 32'($urandom_range(0, 15));
                we_0   = ($urandom_range(0, 3) == 0);
                wd_0   = $urandom;
            end
            if (req_1 && !m_ack1) begin
                if ($urandom_range(0, 9) == 0) req_1 = 1'b0;
            end else begin
                req_1  = ($urandom_range(0, 2) != 0);
                addr_1 = 32'($urandom_range(0, 15));
                we_1   = ($urandom_range(0, 3) == 0);
                wd_1   = $urandom;
            end
        end
        cyc(); resetn = 1'b1; all_low();
        cyc(); settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
